// File: rtl/elevator_call_panel.sv
// Call-latching front end for the elevator controller: edge-captures car and hall
// buttons, cancels calls as floors are served, and tracks pending count and starvation.
module elevator_call_panel #(
    parameter int FLOOR_MIN  = 1,
    parameter int FLOOR_MAX  = 8,
    parameter int WAIT_LIMIT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLOOR_MAX-1:0] btn_car,
    input  logic [FLOOR_MAX-1:0] btn_up,
    input  logic [FLOOR_MAX-1:0] btn_down,
    input  logic [3:0]           current_floor,
    input  logic                 door_state,
    input  logic [1:0]           elevator_state,
    output logic [FLOOR_MAX-1:0] internal_req,
    output logic [FLOOR_MAX-1:0] external_up_req,
    output logic [FLOOR_MAX-1:0] external_down_req,
    output logic [4:0]           pending_count,
    output logic                 overdue
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10,
        ST_HOLD = 2'b11
    } motion_e;

    localparam logic [15:0]          WAIT_MAX = 16'(WAIT_LIMIT);
    localparam logic [31:0]          FMIN_U   = FLOOR_MIN;
    localparam logic [FLOOR_MAX-1:0] LOW_BIT  = {{(FLOOR_MAX-1){1'b0}}, 1'b1};
    localparam logic [FLOOR_MAX-1:0] TOP_BIT  = {1'b1, {(FLOOR_MAX-1){1'b0}}};
    // The top floor has no up button and the bottom floor has no down button.
    localparam logic [FLOOR_MAX-1:0] UP_VALID   = ~TOP_BIT;
    localparam logic [FLOOR_MAX-1:0] DOWN_VALID = ~LOW_BIT;

    logic [FLOOR_MAX-1:0] car_prev;
    logic [FLOOR_MAX-1:0] up_prev;
    logic [FLOOR_MAX-1:0] down_prev;
    logic [15:0]          stall_cnt;

    motion_e              motion;
    logic [31:0]          floor_ext;
    logic [FLOOR_MAX-1:0] svc_hot;
    logic [FLOOR_MAX-1:0] clr_car;
    logic [FLOOR_MAX-1:0] clr_up;
    logic [FLOOR_MAX-1:0] clr_down;
    logic [FLOOR_MAX-1:0] press_car;
    logic [FLOOR_MAX-1:0] press_up;
    logic [FLOOR_MAX-1:0] press_down;
    logic [FLOOR_MAX-1:0] car_next;
    logic [FLOOR_MAX-1:0] up_next;
    logic [FLOOR_MAX-1:0] down_next;
    logic                 any_clear;
    logic [4:0]           count_next;
    logic [15:0]          stall_next;

    function automatic logic [4:0] count_ones(input logic [FLOOR_MAX-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < FLOOR_MAX; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    assign motion    = motion_e'(elevator_state);
    assign floor_ext = {28'd0, current_floor};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        svc_hot = '0;
        for (int i = 0; i < FLOOR_MAX; i++) begin
            if (door_state && (floor_ext == FMIN_U + 32'(i))) begin
                svc_hot[i] = 1'b1;
            end
        end
    end

    // Hall calls are only answered in the direction of travel; the top-floor down
    // call is answered by any arrival because nothing lies above it.
    always_comb begin
        clr_car  = svc_hot;
        clr_up   = svc_hot;
        clr_down = svc_hot;
        if (motion == ST_DOWN) begin
            clr_up = '0;
        end
        if (motion == ST_UP) begin
            clr_down = svc_hot & TOP_BIT;
        end
    end

    always_comb begin
        press_car  = btn_car  & ~car_prev;
        press_up   = btn_up   & ~up_prev   & UP_VALID;
        press_down = btn_down & ~down_prev & DOWN_VALID;

        // Clearing is applied after setting, so a service on the same bit wins.
        car_next  = (internal_req      | press_car)  & ~clr_car;
        up_next   = (external_up_req   | press_up)   & ~clr_up   & UP_VALID;
        down_next = (external_down_req | press_down) & ~clr_down & DOWN_VALID;

        any_clear  = |{internal_req & clr_car,
                       external_up_req & clr_up,
                       external_down_req & clr_down};
        count_next = count_ones(car_next) + count_ones(up_next) + count_ones(down_next);

        if (any_clear || (pending_count == 5'd0)) begin
            stall_next = '0;
        end else if (stall_cnt == WAIT_MAX) begin
            stall_next = stall_cnt;
        end else begin
            stall_next = stall_cnt + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        // Edge detectors track the buttons even in reset so a held button never latches.
        car_prev  <= btn_car;
        up_prev   <= btn_up;
        down_prev <= btn_down;
        if (rst) begin
            internal_req      <= '0;
            external_up_req   <= '0;
            external_down_req <= '0;
            pending_count     <= '0;
            stall_cnt         <= '0;
            overdue           <= 1'b0;
        end else begin
            internal_req      <= car_next;
            external_up_req   <= up_next;
            external_down_req <= down_next;
            pending_count     <= count_next;
            stall_cnt         <= stall_next;
            overdue           <= (stall_next == WAIT_MAX);
        end
    end

endmodule

// File: tb/tb_elevator_call_panel.sv
// Self-checking bench for elevator_call_panel: directed scenarios plus randomized
// traffic compared against a per-floor behavioural model.
module tb_elevator_call_panel;

    localparam int LIMIT = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] btn_car = '0;
    logic [7:0] btn_up = '0;
    logic [7:0] btn_down = '0;
    logic [3:0] current_floor = 4'd1;
    logic       door_state = 1'b0;
    logic [1:0] elevator_state = 2'b00;
    logic [7:0] internal_req;
    logic [7:0] external_up_req;
    logic [7:0] external_down_req;
    logic [4:0] pending_count;
    logic       overdue;

    int checks = 0;
    int errors = 0;

    // Reference model state: one flag per floor per call type.
    bit [7:0] m_car, m_up, m_dn;
    bit [7:0] p_car, p_up, p_dn;
    int       m_cnt;

    elevator_call_panel #(
        .FLOOR_MIN (1),
        .FLOOR_MAX (8),
        .WAIT_LIMIT(LIMIT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .btn_car          (btn_car),
        .btn_up           (btn_up),
        .btn_down         (btn_down),
        .current_floor    (current_floor),
        .door_state       (door_state),
        .elevator_state   (elevator_state),
        .internal_req     (internal_req),
        .external_up_req  (external_up_req),
        .external_down_req(external_down_req),
        .pending_count    (pending_count),
        .overdue          (overdue)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit [7:0] nc, nu, nd;
        bit       svc, hit, pc, pu, pd, cu, cd, cleared;
        int       s, old_pend;
        if (rst) begin
            m_car = '0; m_up = '0; m_dn = '0; m_cnt = 0;
        end else begin
            svc = door_state && (current_floor >= 1) && (current_floor <= 8);
            s = int'(current_floor) - 1;
            old_pend = $countones(m_car) + $countones(m_up) + $countones(m_dn);
            cleared = 0;
            for (int f = 0; f < 8; f++) begin
                hit = svc && (f == s);
                pc = btn_car[f] && !p_car[f];
                pu = btn_up[f] && !p_up[f] && (f != 7);
                pd = btn_down[f] && !p_dn[f] && (f != 0);
                cu = hit && (elevator_state != 2'b10);
                cd = hit && ((elevator_state != 2'b01) || (f == 7));
                if ((hit && m_car[f]) || (cu && m_up[f]) || (cd && m_dn[f])) cleared = 1;
                nc[f] = (m_car[f] || pc) && !hit;
                nu[f] = (m_up[f] || pu) && !cu;
                nd[f] = (m_dn[f] || pd) && !cd;
            end
            m_car = nc; m_up = nu; m_dn = nd;
            if (cleared || old_pend == 0) m_cnt = 0;
            else if (m_cnt < LIMIT) m_cnt = m_cnt + 1;
        end
        p_car = btn_car; p_up = btn_up; p_dn = btn_down;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_car = '0; btn_up = '0; btn_down = '0;
        door_state = 1'b0; current_floor = 4'd1; elevator_state = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (internal_req !== 8'h00) begin errors++; $display("FAIL reset_car got %h want 00", internal_req); end
        if (external_up_req !== 8'h00) begin errors++; $display("FAIL reset_up got %h want 00", external_up_req); end
        if (external_down_req !== 8'h00) begin errors++; $display("FAIL reset_down got %h want 00", external_down_req); end
        if (pending_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", pending_count); end
        if (overdue !== 1'b0) begin errors++; $display("FAIL reset_overdue got %b want 0", overdue); end
    endtask

    task automatic test_held_through_reset();
        rst = 1'b1;
        btn_car = 8'h08;
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks += 2;
        if (internal_req !== 8'h00) begin errors++; $display("FAIL held_car got %h want 00", internal_req); end
        if (pending_count !== 5'd0) begin errors++; $display("FAIL held_count got %0d want 0", pending_count); end
        btn_car = 8'h00;
        tick();
        btn_car = 8'h08;
        tick();
        checks += 2;
        if (internal_req !== 8'h08) begin errors++; $display("FAIL repress_car got %h want 08", internal_req); end
        if (pending_count !== 5'd1) begin errors++; $display("FAIL repress_count got %0d want 1", pending_count); end
        btn_car = 8'h00;
        tick();
    endtask

    task automatic test_direction_clear();
        do_reset();
        btn_up = 8'h20; btn_down = 8'h20;
        tick();
        btn_up = 8'h00; btn_down = 8'h00;
        checks += 2;
        if (external_up_req !== 8'h20) begin errors++; $display("FAIL dir_latch_up got %h want 20", external_up_req); end
        if (external_down_req !== 8'h20) begin errors++; $display("FAIL dir_latch_down got %h want 20", external_down_req); end
        door_state = 1'b1; current_floor = 4'd6; elevator_state = 2'b01;
        tick();
        door_state = 1'b0;
        checks += 3;
        if (external_up_req !== 8'h00) begin errors++; $display("FAIL dir_up_cleared got %h want 00", external_up_req); end
        if (external_down_req !== 8'h20) begin errors++; $display("FAIL dir_down_kept got %h want 20", external_down_req); end
        if (pending_count !== 5'd1) begin errors++; $display("FAIL dir_count got %0d want 1", pending_count); end
        door_state = 1'b1; elevator_state = 2'b10;
        tick();
        door_state = 1'b0;
        checks += 2;
        if (external_down_req !== 8'h00) begin errors++; $display("FAIL dir_down_cleared got %h want 00", external_down_req); end
        if (pending_count !== 5'd0) begin errors++; $display("FAIL dir_count2 got %0d want 0", pending_count); end
    endtask

    task automatic test_boundary();
        do_reset();
        btn_down = 8'h01; btn_up = 8'h80;
        tick();
        btn_down = 8'h00; btn_up = 8'h00;
        tick();
        checks += 3;
        if (external_up_req !== 8'h00) begin errors++; $display("FAIL bnd_up got %h want 00", external_up_req); end
        if (external_down_req !== 8'h00) begin errors++; $display("FAIL bnd_down got %h want 00", external_down_req); end
        if (pending_count !== 5'd0) begin errors++; $display("FAIL bnd_count got %0d want 0", pending_count); end
        btn_down = 8'h80;
        tick();
        btn_down = 8'h00;
        checks += 1;
        if (external_down_req !== 8'h80) begin errors++; $display("FAIL bnd_top_latch got %h want 80", external_down_req); end
        door_state = 1'b1; current_floor = 4'd8; elevator_state = 2'b01;
        tick();
        door_state = 1'b0;
        checks += 1;
        if (external_down_req !== 8'h00) begin errors++; $display("FAIL bnd_top_clear got %h want 00", external_down_req); end
    endtask

    task automatic test_clear_wins();
        do_reset();
        door_state = 1'b1; current_floor = 4'd2; elevator_state = 2'b00;
        btn_car = 8'h02;
        tick();
        checks += 1;
        if (internal_req !== 8'h00) begin errors++; $display("FAIL cw_same_cycle got %h want 00", internal_req); end
        door_state = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 1;
            if (internal_req !== 8'h00) begin errors++; $display("FAIL cw_held got %h want 00", internal_req); end
        end
        btn_car = 8'h00;
        tick();
    endtask

    task automatic test_starvation();
        do_reset();
        btn_car = 8'h80;
        tick();
        btn_car = 8'h00;
        checks += 1;
        if (internal_req !== 8'h80) begin errors++; $display("FAIL stv_latch got %h want 80", internal_req); end
        for (int k = 1; k < LIMIT; k++) begin
            tick();
            checks += 1;
            if (overdue !== 1'b0) begin errors++; $display("FAIL stv_early edge %0d got %b want 0", k, overdue); end
        end
        tick();
        checks += 1;
        if (overdue !== 1'b1) begin errors++; $display("FAIL stv_rise got %b want 1", overdue); end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks += 1;
            if (overdue !== 1'b1) begin errors++; $display("FAIL stv_saturate got %b want 1", overdue); end
        end
        door_state = 1'b1; current_floor = 4'd8; elevator_state = 2'b00;
        tick();
        door_state = 1'b0;
        checks += 2;
        if (overdue !== 1'b0) begin errors++; $display("FAIL stv_fall got %b want 0", overdue); end
        if (pending_count !== 5'd0) begin errors++; $display("FAIL stv_count got %0d want 0", pending_count); end
    endtask

    task automatic test_count_out_of_range();
        logic [3:0] bad_floor [3] = '{4'd0, 4'd9, 4'd15};
        do_reset();
        btn_car = 8'h15; btn_up = 8'h0a; btn_down = 8'h40;
        tick();
        btn_car = 8'h00; btn_up = 8'h00; btn_down = 8'h00;
        checks += 1;
        if (pending_count !== 5'd6) begin errors++; $display("FAIL cnt_six got %0d want 6", pending_count); end
        for (int i = 0; i < 3; i++) begin
            door_state = 1'b1; current_floor = bad_floor[i]; elevator_state = 2'b00;
            tick();
            checks += 4;
            if (internal_req !== 8'h15) begin errors++; $display("FAIL oor_car floor %0d got %h want 15", bad_floor[i], internal_req); end
            if (external_up_req !== 8'h0a) begin errors++; $display("FAIL oor_up floor %0d got %h want 0a", bad_floor[i], external_up_req); end
            if (external_down_req !== 8'h40) begin errors++; $display("FAIL oor_down floor %0d got %h want 40", bad_floor[i], external_down_req); end
            if (pending_count !== 5'd6) begin errors++; $display("FAIL oor_count floor %0d got %0d want 6", bad_floor[i], pending_count); end
        end
        door_state = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        btn_car = 8'hff;
        tick();
        btn_car = 8'h00;
        tick();
        rst = 1'b1;
        btn_up = 8'h01;
        tick();
        checks += 2;
        if (internal_req !== 8'h00) begin errors++; $display("FAIL rmid_car got %h want 00", internal_req); end
        if (pending_count !== 5'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", pending_count); end
        rst = 1'b0;
        tick();
        checks += 1;
        if (external_up_req !== 8'h00) begin errors++; $display("FAIL rmid_held_up got %h want 00", external_up_req); end
        btn_up = 8'h00;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst            = ($urandom_range(0, 63) == 0);
            btn_car        = 8'($urandom & $urandom & $urandom);
            btn_up         = 8'($urandom & $urandom & $urandom);
            btn_down       = 8'($urandom & $urandom & $urandom);
            door_state     = ($urandom_range(0, 4) == 0);
            current_floor  = 4'($urandom_range(0, 10));
            elevator_state = 2'($urandom_range(0, 3));
            tick();
            checks += 5;
            if (internal_req !== m_car) begin errors++; $display("FAIL rnd_car cyc %0d got %h want %h", n, internal_req, m_car); end
            if (external_up_req !== m_up) begin errors++; $display("FAIL rnd_up cyc %0d got %h want %h", n, external_up_req, m_up); end
            if (external_down_req !== m_dn) begin errors++; $display("FAIL rnd_down cyc %0d got %h want %h", n, external_down_req, m_dn); end
            if (pending_count !== 5'($countones(m_car) + $countones(m_up) + $countones(m_dn))) begin
                errors++;
                $display("FAIL rnd_count cyc %0d got %0d want %0d", n, pending_count,
                         $countones(m_car) + $countones(m_up) + $countones(m_dn));
            end
            if (overdue !== (m_cnt == LIMIT)) begin errors++; $display("FAIL rnd_overdue cyc %0d got %b want %b", n, overdue, m_cnt == LIMIT); end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_held_through_reset();
        test_direction_clear();
        test_boundary();
        test_clear_wins();
        test_starvation();
        test_count_out_of_range();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
